// File: rtl/bomb_pkg.sv
// Shared constants for the bomb countdown display: glyphs, glyph codes,
// FSM encoding and the binary-to-BCD helper.
package bomb_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [0:0] ST_ARMED = 1'b0;
  localparam logic [0:0] ST_BLOWN = 1'b1;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_O     = 7'b1000000;
  localparam logic [6:0] GLYPH_M     = 7'b1001000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_B     = 4'd10;
  localparam logic [3:0] CODE_O     = 4'd11;
  localparam logic [3:0] CODE_M     = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Returns {tens[1:0], ones[3:0]} for 0..31 using only compare/subtract.
  function automatic logic [5:0] bin_to_bcd(input logic [4:0] v);
    logic [1:0] tens;
    logic [3:0] ones;
    if (v >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(v - 5'd10);
    end else begin
      tens = 2'd0;
      ones = v[3:0];
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational glyph lookup: 0-9 digits, 10=b, 11=O, 12=M, anything else blank.
module seg7_encode
  import bomb_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (code)
      4'd0:   glyph = GLYPH_0;
      4'd1:   glyph = GLYPH_1;
      4'd2:   glyph = GLYPH_2;
      4'd3:   glyph = GLYPH_3;
      4'd4:   glyph = GLYPH_4;
      4'd5:   glyph = GLYPH_5;
      4'd6:   glyph = GLYPH_6;
      4'd7:   glyph = GLYPH_7;
      4'd8:   glyph = GLYPH_8;
      4'd9:   glyph = GLYPH_9;
      CODE_B: glyph = GLYPH_B;
      CODE_O: glyph = GLYPH_O;
      CODE_M: glyph = GLYPH_M;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/bomb_display_driver.sv
// Multiplexed 4-digit 7-segment driver: shows the countdown while ARMED,
// blinks "bOOM" once BLOWN until reset.
module bomb_display_driver
  import bomb_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] Counter_In,
  input  logic       Blow_Up,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic       Dp
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic [4:0]         snapshot;
  logic               fresh;
  logic [0:0]         state;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_on;

  logic       scan_wrap;
  logic       frame_wrap;
  logic       load_snap;
  logic [4:0] snap_eff;
  logic [5:0] bcd;
  logic [1:0] tens;
  logic [3:0] ones;
  logic [3:0] code;
  logic [3:0] an_next;
  logic [6:0] glyph;

  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (digit_idx == 2'(NUM_DIGITS - 1));
  // The first cycle after reset also loads, and the display uses the value
  // being loaded so that cycle already shows the fresh snapshot.
  assign load_snap  = fresh || frame_wrap;
  assign snap_eff   = load_snap ? Counter_In : snapshot;
  assign bcd        = bin_to_bcd(snap_eff);
  assign tens       = bcd[5:4];
  assign ones       = bcd[3:0];

  always_comb begin
    code    = CODE_BLANK;
    an_next = 4'b1111;
    if (state == ST_ARMED) begin
      case (digit_idx)
        2'd0: begin
          code    = ones;
          an_next = 4'b1110;
        end
        2'd1: begin
          if (tens != 2'd0) begin
            code    = {2'b00, tens};
            an_next = 4'b1101;
          end
        end
        default: ;
      endcase
    end else if (phase_on) begin
      an_next = ~(4'b0001 << digit_idx);
      case (digit_idx)
        2'd0:    code = CODE_M;
        2'd3:    code = CODE_B;
        default: code = CODE_O;
      endcase
    end
  end

  seg7_encode u_encode (
    .code  (code),
    .glyph (glyph)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      snapshot  <= 5'd15;
      fresh     <= 1'b1;
      state     <= ST_ARMED;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
      Seg       <= GLYPH_BLANK;
      An        <= 4'b1111;
      Dp        <= 1'b1;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_wrap)
        digit_idx <= digit_idx + 2'd1;
      fresh <= 1'b0;
      if (load_snap)
        snapshot <= Counter_In;
      Seg <= glyph;
      An  <= an_next;
      Dp  <= 1'b1;

      // Blow_Up is honoured on any cycle; the scan keeps running untouched.
      if (state == ST_ARMED) begin
        if (Blow_Up) begin
          state     <= ST_BLOWN;
          blink_cnt <= '0;
          phase_on  <= 1'b1;
        end
      end else if (frame_wrap) begin
        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/bomb_display_driver.md
BOMB_DISPLAY_DRIVER -- requirements
Module: bomb_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, Clock cycles per digit slot; legal range >= 2.
REQ-002 Parameter BLINK_FRAMES, default 100, full 4-digit scan frames per blink half-period; legal range >= 1.
REQ-003 Port Clock  input  1  single system clock; all logic on posedge.
REQ-004 Port Reset  input  1  reset, synchronous, active-high.
REQ-005 Port Counter_In  input  5  countdown value from the timer stage, unsigned 0..31.
REQ-006 Port Blow_Up  input  1  detonation flag from the timer stage, level.
REQ-007 Port Seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 Port An  output  4  digit enables, active-low, one-hot-low or all-high, registered; An[0] = rightmost digit.
REQ-009 Port Dp  output  1  decimal point, active-low, registered; always 1 (off).

Function
REQ-010 Scan counter counts 0..SCAN_DIV-1 and wraps; on wrap, digit index advances 0->1->2->3->0.
REQ-011 Frame boundary = scan-counter wrap while digit index is 3; Counter_In is snapshotted only at a frame boundary and after reset, so no frame mixes two values.
REQ-012 Binary-to-BCD: tens = snapshot/10 (0..3), ones = snapshot mod 10; combinational, no division operator beyond constant compare/subtract.
REQ-013 FSM states: ARMED, BLOWN.
REQ-014 ARMED: digit 0 shows ones glyph, digit 1 shows tens glyph, with the tens digit blanked (An[1] high) when tens = 0; digits 2 and 3 blanked.
REQ-015 ARMED -> BLOWN when Blow_Up is sampled 1 on any cycle, not only at a frame boundary; BLOWN is left only by Reset.
REQ-016 On entering BLOWN, the scan counter and digit index continue without restart; the blink phase is set to ON and the blink counter to 0.
REQ-017 BLOWN, phase ON: digits 3..0 show "b","O","O","M"; phase OFF: An = 4'b1111.
REQ-018 Blink counter counts frame boundaries 0..BLINK_FRAMES-1; on wrap, the phase toggles.
REQ-019 Glyphs (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, b=0000011, O=1000000, M=1001000, blank=1111111.
REQ-020 Outputs register the digit index and glyph of the same cycle: a new digit is visible one Clock after the index changes.
REQ-021 Blow_Up and Reset both 1: Reset wins.
REQ-022 Counter_In 16..31 is displayed literally (e.g. 31 -> "31"); there is no saturation.

Reset
REQ-023 While Reset = 1, on each posedge: scan counter 0, digit index 0, snapshot 15, state ARMED, blink counter 0, phase ON.
REQ-024 Registered outputs during Reset: Seg = 1111111, An = 1111, Dp = 1.
REQ-025 On the first cycle after Reset deasserts, An[0] = 0 and Seg shows the ones glyph of the snapshot taken on that cycle.
REQ-026 Reset mid-blink or mid-scan has the same effect as power-up reset; no state is retained.

Structure
REQ-027 Shared package bomb_pkg holds the glyph constants, the state encoding (ARMED=0, BLOWN=1) and the digit-count constant 4.
REQ-028 One sub-module, seg7_encode: combinational 4-bit code -> 7-bit glyph; codes 0-9 are digits, 10=b, 11=O, 12=M, 15=blank.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-029 Reset, Counter_In=15 -> An cycles 1110,1101,1111,1111 every 4 clocks; Seg = 0010010 on An[0], 1111001 on An[1].
REQ-030 Counter_In 15->7 mid-frame -> old value held until the next frame boundary; then An[1] stays high (tens blanked) and digit 0 shows 1111000.
REQ-031 Counter_In=0, Blow_Up pulsed 1 for 1 cycle -> BLOWN latched; "bOOM" shown for 2 frames (32 clocks), then An=1111 for 32 clocks, repeating.
REQ-032 Reset asserted in BLOWN phase OFF -> next cycle Seg=1111111, An=1111; after release, ARMED with 15 displayed.
REQ-033 Counter_In=31 -> digit 1 = 0110000, digit 0 = 1111001.
REQ-034 Reset and Blow_Up both 1 for 3 cycles, then Reset=0 with Blow_Up=0 -> state ARMED.
